// File: rtl/decoder_scan_ctrl.sv
// -----------------------------------------------------------------------------
// decoder_scan_ctrl
//
// Upstream sequencer for a 3-to-8 enabled decoder. It walks through the
// channels enabled in `mask` and holds each one for a programmable dwell time.
// Between channels it can insert blanking cycles, so the decoder never shows
// two channels back-to-back. It supports continuous and single-sweep modes.
//
// Parameters:
//   DWELL_W      width of the dwell input and of the dwell counter
//   BLANK_CYCLES number of cycles sel_en is held low between channels (0..15)
//
// Ports:
//   clk     system clock, rising edge
//   rst_n   asynchronous active-low reset
//   start   begin a scan (ignored while busy or when mask == 0)
//   stop    abort the scan; has priority over start and over any advance
//   mode    0 = continuous, 1 = single sweep; latched when a start is accepted
//   mask    channel enables, bit i enables channel i
//   dwell   active cycles per channel; 0 is treated as 1
//   sel     registered channel index, drives the decoder `in`
//   sel_en  registered enable, drives the decoder `en`
//   busy    high while in ACTIVE or BLANK
//   done    one-cycle pulse when a single sweep completes
// -----------------------------------------------------------------------------
module decoder_scan_ctrl #(
    parameter int DWELL_W      = 8,
    parameter int BLANK_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [7:0]         mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2:0]         sel,
    output logic               sel_en,
    output logic               busy,
    output logic               done
);

    // A zero-width counter is not legal, so keep at least one bit even when
    // blanking is disabled (the BLANK state is then never entered).
    localparam int BLANK_W = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
    localparam logic [BLANK_W-1:0] BLANK_LOAD =
        BLANK_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        BLANK  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         sel_q, sel_d;
    logic               sel_en_q, sel_en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               mode_q, mode_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [BLANK_W-1:0] blank_cnt_q, blank_cnt_d;

    // Index of the lowest set bit (0 when none is set).
    function automatic logic [2:0] lowest_set(input logic [7:0] m);
        lowest_set = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) lowest_set = 3'(i);
        end
    endfunction

    // The dwell counter runs from eff_dwell-1 down to 0, so its load value is
    // max(dwell,1)-1.
    logic [DWELL_W-1:0] dwell_load;
    assign dwell_load = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

    // Channels strictly above the current one. An upward search from sel+1
    // finds the lowest of these; if none exist, a wrapped search lands on the
    // lowest set bit of the whole mask (which may be sel itself).
    logic [7:0] above_mask;
    for (genvar gi = 0; gi < 8; gi++) begin : g_above
        assign above_mask[gi] = mask[gi] && (3'(gi) > sel_q);
    end

    logic       next_go;
    logic       next_done;
    logic [2:0] next_sel;

    always_comb begin
        next_go   = 1'b0;
        next_done = 1'b0;
        next_sel  = sel_q;
        if (mask == 8'h00) begin
            // nothing left to scan: return to IDLE without a done pulse
        end else if (above_mask != 8'h00) begin
            next_go  = 1'b1;
            next_sel = lowest_set(above_mask);
        end else if (!mode_q) begin
            next_go  = 1'b1;
            next_sel = lowest_set(mask);
        end else begin
            next_done = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        mode_d      = mode_q;
        dwell_cnt_d = dwell_cnt_q;
        blank_cnt_d = blank_cnt_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !stop && (mask != 8'h00)) begin
                    mode_d      = mode;
                    sel_d       = lowest_set(mask);
                    dwell_cnt_d = dwell_load;
                    state_d     = ACTIVE;
                end
            end
            ACTIVE, BLANK: begin
                if (stop) begin
                    state_d = IDLE;
                end else if ((state_q == ACTIVE) && (dwell_cnt_q != '0)) begin
                    dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
                end else if ((state_q == BLANK) && (blank_cnt_q != '0)) begin
                    blank_cnt_d = blank_cnt_q - BLANK_W'(1);
                end else if ((state_q == ACTIVE) && (BLANK_CYCLES > 0)) begin
                    state_d     = BLANK;
                    blank_cnt_d = BLANK_LOAD;
                end else if (next_go) begin
                    // Entering a new channel: dwell is re-sampled here.
                    sel_d       = next_sel;
                    dwell_cnt_d = dwell_load;
                    state_d     = ACTIVE;
                end else begin
                    state_d = IDLE;
                    done_d  = next_done;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        sel_en_d = (state_d == ACTIVE);
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= 3'd0;
            sel_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mode_q      <= 1'b0;
            dwell_cnt_q <= '0;
            blank_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            sel_en_q    <= sel_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mode_q      <= mode_d;
            dwell_cnt_q <= dwell_cnt_d;
            blank_cnt_q <= blank_cnt_d;
        end
    end

    assign sel    = sel_q;
    assign sel_en = sel_en_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
module tb_decoder_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       mode;
    logic [7:0] mask;
    logic [7:0] dwell;

    logic [2:0] sel,  sel_z;
    logic       sel_en, sel_en_z;
    logic       busy, busy_z;
    logic       done, done_z;

    int checks   = 0;
    int failures = 0;

    // Main instance with one blanking cycle.
    decoder_scan_ctrl #(.DWELL_W(8), .BLANK_CYCLES(1)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .stop   (stop),
        .mode   (mode),
        .mask   (mask),
        .dwell  (dwell),
        .sel    (sel),
        .sel_en (sel_en),
        .busy   (busy),
        .done   (done)
    );

    // Second instance with blanking disabled; shares the stimulus.
    decoder_scan_ctrl #(.DWELL_W(8), .BLANK_CYCLES(0)) dut_nb (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .stop   (stop),
        .mode   (mode),
        .mask   (mask),
        .dwell  (dwell),
        .sel    (sel_z),
        .sel_en (sel_en_z),
        .busy   (busy_z),
        .done   (done_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       stop;
        logic       mode;
        logic [7:0] mask;
        logic [7:0] dwell;
        logic [2:0] e_sel;
        logic       e_en;
        logic       e_busy;
        logic       e_done;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic st, input logic sp, input logic md,
                       input logic [7:0] mk, input logic [7:0] dw,
                       input logic [2:0] es, input logic ee,
                       input logic eb, input logic ed);
        vec_t v;
        v.start = st; v.stop = sp; v.mode = md; v.mask = mk; v.dwell = dw;
        v.e_sel = es; v.e_en = ee; v.e_busy = eb; v.e_done = ed;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        mode  = 1'b0;
        mask  = 8'h00;
        dwell = 8'd0;
        step();
        step();
        chk("reset sel",    8'(sel),    8'h0);
        chk("reset sel_en", 8'(sel_en), 8'h0);
        chk("reset busy",   8'(busy),   8'h0);
        chk("reset done",   8'(done),   8'h0);
        rst_n = 1'b1;
        step();
        chk("post-reset idle sel_en", 8'(sel_en), 8'h0);

        // Each row: inputs before the edge -> outputs after the edge.
        //   st sp md mask   dwell  sel en busy done
        // Continuous, mask A5, dwell 2: 0,2,5,7,0,2 each 2 high + 1 blank.
        add(1, 0, 0, 8'hA5, 8'd2, 3'd0, 1, 1, 0);
        add(0, 0, 0, 8'hA5, 8'd2, 3'd0, 1, 1, 0);
        add(0, 0, 0, 8'hA5, 8'd2, 3'd0, 0, 1, 0);
        add(0, 0, 0, 8'hA5, 8'd2, 3'd2, 1, 1, 0);
        add(1, 0, 0, 8'hA5, 8'd2, 3'd2, 1, 1, 0); // start while busy: ignored
        add(0, 0, 0, 8'hA5, 8'd2, 3'd2, 0, 1, 0);
        add(0, 0, 0, 8'hA5, 8'd2, 3'd5, 1, 1, 0);
        add(0, 0, 0, 8'hA5, 8'd2, 3'd5, 1, 1, 0);
        add(0, 0, 0, 8'hA5, 8'd2, 3'd5, 0, 1, 0);
        add(0, 0, 0, 8'hA5, 8'd2, 3'd7, 1, 1, 0);
        add(0, 0, 0, 8'hA5, 8'd2, 3'd7, 1, 1, 0);
        add(0, 0, 0, 8'hA5, 8'd2, 3'd7, 0, 1, 0);
        add(0, 0, 0, 8'hA5, 8'd2, 3'd0, 1, 1, 0); // wrap
        add(0, 0, 0, 8'hA5, 8'd2, 3'd0, 1, 1, 0);
        add(0, 0, 0, 8'hA5, 8'd2, 3'd0, 0, 1, 0);
        add(0, 0, 0, 8'hA5, 8'd2, 3'd2, 1, 1, 0); // channel 2, 1st dwell cycle
        add(0, 0, 0, 8'hA5, 8'd2, 3'd2, 1, 1, 0); // channel 2, 2nd dwell cycle
        add(0, 1, 0, 8'hA5, 8'd2, 3'd2, 0, 0, 0); // stop beats advance
        add(0, 0, 0, 8'hA5, 8'd2, 3'd2, 0, 0, 0);
        add(1, 1, 0, 8'hA5, 8'd2, 3'd2, 0, 0, 0); // start+stop from IDLE
        add(1, 0, 0, 8'h00, 8'd2, 3'd2, 0, 0, 0); // start with empty mask
        // Single sweep, mask 01, dwell 0 -> 1 active, 1 blank, done.
        add(1, 0, 1, 8'h01, 8'd0, 3'd0, 1, 1, 0);
        add(0, 0, 1, 8'h01, 8'd0, 3'd0, 0, 1, 0);
        add(0, 0, 1, 8'h01, 8'd0, 3'd0, 0, 0, 1);
        add(0, 0, 1, 8'h01, 8'd0, 3'd0, 0, 0, 0);
        // Single sweep over channels 1 and 4, dwell 1.
        add(1, 0, 1, 8'h12, 8'd1, 3'd1, 1, 1, 0);
        add(0, 0, 1, 8'h12, 8'd1, 3'd1, 0, 1, 0);
        add(0, 0, 1, 8'h12, 8'd1, 3'd4, 1, 1, 0);
        add(0, 0, 1, 8'h12, 8'd1, 3'd4, 0, 1, 0);
        add(0, 0, 1, 8'h12, 8'd1, 3'd4, 0, 0, 1);
        add(0, 0, 1, 8'h12, 8'd1, 3'd4, 0, 0, 0);
        // Mask FF -> 00 mid-dwell (dwell also changed): channel finishes.
        add(1, 0, 0, 8'hFF, 8'd3, 3'd0, 1, 1, 0);
        add(0, 0, 0, 8'h00, 8'd9, 3'd0, 1, 1, 0);
        add(0, 0, 0, 8'h00, 8'd9, 3'd0, 1, 1, 0);
        add(0, 0, 0, 8'h00, 8'd9, 3'd0, 0, 1, 0);
        add(0, 0, 0, 8'h00, 8'd9, 3'd0, 0, 0, 0);
        add(0, 0, 0, 8'h00, 8'd9, 3'd0, 0, 0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            start = vq[i].start;
            stop  = vq[i].stop;
            mode  = vq[i].mode;
            mask  = vq[i].mask;
            dwell = vq[i].dwell;
            step();
            chk($sformatf("vec%0d sel", i),    8'(sel),    8'(vq[i].e_sel));
            chk($sformatf("vec%0d sel_en", i), 8'(sel_en), 8'(vq[i].e_en));
            chk($sformatf("vec%0d busy", i),   8'(busy),   8'(vq[i].e_busy));
            chk($sformatf("vec%0d done", i),   8'(done),   8'(vq[i].e_done));
            $display("vec %0d: st=%0d sp=%0d mask=%02h -> sel=%0d en=%0d busy=%0d done=%0d",
                     i, start, stop, mask, sel, sel_en, busy, done);
        end
        start = 1'b0;
        stop  = 1'b0;

        // No blanking: mask 0C, dwell 3 -> 2,3,2,3 each 3 cycles, en stays high.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        mode  = 1'b0;
        mask  = 8'h0C;
        dwell = 8'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) step();
            chk($sformatf("noblank k%0d sel", k),    8'(sel_z),    (((k / 3) % 2) != 0) ? 8'd3 : 8'd2);
            chk($sformatf("noblank k%0d sel_en", k), 8'(sel_en_z), 8'd1);
            chk($sformatf("noblank k%0d busy", k),   8'(busy_z),   8'd1);
            chk($sformatf("noblank k%0d done", k),   8'(done_z),   8'd0);
            $display("noblank cycle %0d: sel=%0d en=%0d", k, sel_z, sel_en_z);
        end

        // Asynchronous reset mid-ACTIVE on channel 5.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        mask  = 8'h20;
        dwell = 8'd5;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("pre-reset sel",    8'(sel),    8'd5);
        chk("pre-reset sel_en", 8'(sel_en), 8'd1);
        step();
        #3;
        rst_n = 1'b0;
        #1;
        chk("async reset sel",    8'(sel),    8'd0);
        chk("async reset sel_en", 8'(sel_en), 8'd0);
        chk("async reset busy",   8'(busy),   8'd0);
        chk("async reset done",   8'(done),   8'd0);
        $display("async reset: sel=%0d en=%0d busy=%0d", sel, sel_en, busy);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("after reset k%0d sel_en", k), 8'(sel_en), 8'd0);
            chk($sformatf("after reset k%0d busy", k),   8'(busy),   8'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
